// File: rtl/io_bus_master.sv
// io_bus_master: turns one CPU load/store into one IO bus transaction.
// Option IO_BUS_MASTER_BUSERR_EN: unmapped devices complete at once with cpu_err.
module io_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int WE_BIT  = 0,
    parameter int NUM_DEV = 4,
    parameter int DEV_LO  = 8,
    parameter int DEV_HI  = 11,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [NUM_DEV-1:0] bg,
    output logic [ADDR_W-1:0] io_addr,
    output logic [CTRL_W-1:0] io_ctrl,
    inout  wire  [DATA_W-1:0] io_data
);

    localparam int DEV_W = DEV_HI - DEV_LO + 1;
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [3:0]        cnt, cnt_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DEV_W-1:0]  dev_q;
    logic              map_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic [DEV_W-1:0]  dev;
    logic              mapped;
    logic              skip;
    logic              rd_cap;

    assign dev    = cpu_addr[DEV_HI:DEV_LO];
    assign mapped = int'(dev) < NUM_DEV;

`ifdef IO_BUS_MASTER_BUSERR_EN
    assign skip = !mapped;
`else
    assign skip = 1'b0;
`endif

    assign rd_cap = (state == ACCESS) && (cnt == 4'd0) && !we_q;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_nx = skip ? DONE : ACCESS;
                    cnt_nx   = cpu_we ? 4'd0 : RD_LAT_C;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) state_nx = DONE;
                else cnt_nx = cnt - 4'd1;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dev_q   <= '0;
            map_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                dev_q   <= dev;
                map_q   <= mapped;
                err_q   <= skip;
                if (skip && !cpu_we) rdata_q <= '0;
            end
            // nobody drives the bus for an unmapped read, so return zero
            if (rd_cap) rdata_q <= map_q ? io_data : '0;
        end
    end

    always_comb begin
        bg      = '0;
        io_addr = '0;
        io_ctrl = '0;
        if (state == ACCESS) begin
            io_addr         = addr_q;
            io_ctrl[WE_BIT] = we_q;
            for (int i = 0; i < NUM_DEV; i++) begin
                bg[i] = map_q && (int'(dev_q) == i);
            end
        end
    end

    assign io_data   = (state == ACCESS && we_q) ? wdata_q : 'z;
    assign cpu_busy  = (state == ACCESS);
    assign cpu_done  = (state == DONE);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: random and directed loads/stores against a
// transaction-level model, checked by a scoreboard monitor.
module tb_io_bus_master;

    localparam int RD_LAT = 1;
    localparam int ND     = 4;
`ifdef IO_BUS_MASTER_BUSERR_EN
    localparam bit BUSERR = 1'b1;
`else
    localparam bit BUSERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_busy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [3:0]  bg;
    logic [31:0] io_addr;
    logic [3:0]  io_ctrl;
    wire  [31:0] io_data;

    logic        drv_en;
    logic [31:0] drv_val;

    always #5 clk = ~clk;

    io_bus_master #(
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy),
        .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .bg(bg),
        .io_addr(io_addr),
        .io_ctrl(io_ctrl),
        .io_data(io_data)
    );

    // peripheral contents: address 0 reads 0x12345678
    function automatic logic [31:0] periph(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    always_comb begin
        drv_en  = (bg != 4'b0) && !io_ctrl[0];
        drv_val = periph(io_addr);
    end
    assign io_data = drv_en ? drv_val : 'z;

    typedef struct {
        int          a;
        int          done_k;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  bg;
        logic        err;
    } txn_t;

    txn_t sb[$];
    int   edges = 0;
    logic rst_seen = 1'b0;
    int   free_k = 0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin
        edges    <= edges + 1;
        rst_seen <= rst;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp,
                     edges);
        end
    endtask

    // one cycle of stimulus; the model decides whether the edge accepts
    task automatic drive(input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic acc);
        txn_t t;
        int   k;
        int   dv;
        @(negedge clk);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        k   = edges + 1;
        acc = 1'b0;
        if (req && !rst && k >= free_k) begin
            acc     = 1'b1;
            dv      = int'(addr[11:8]);
            t.a     = k;
            t.we    = we;
            t.addr  = addr;
            t.wdata = wd;
            t.bg    = (dv < ND) ? 4'(1 << dv) : 4'b0;
            t.err   = 1'b0;
            if (dv >= ND && BUSERR) begin
                t.done_k = k;
                t.err    = 1'b1;
            end else begin
                t.done_k = k + (we ? 1 : RD_LAT + 1);
            end
            t.rdata = (dv < ND) ? periph(addr) : 32'h0;
            sb.push_back(t);
            free_k = t.done_k + 2;
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive(1'b1, we, addr, wd, acc);
        drive(1'b0, 1'b0, 32'h0, 32'h0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        free_k = 0;
    endtask

    // monitor / scoreboard
    initial begin
        txn_t t;
        int   k;
        logic act;
        logic dn;
        forever begin
            @(negedge clk);
            k = edges;
            if (rst_seen) begin
                chk("rst_bg", 32'(bg), 32'h0);
                chk("rst_busy", 32'(cpu_busy), 32'h0);
                chk("rst_done", 32'(cpu_done), 32'h0);
                chk("rst_err", 32'(cpu_err), 32'h0);
                chk("rst_rdata", cpu_rdata, 32'h0);
                chk("rst_io_addr", io_addr, 32'h0);
                chk("rst_io_ctrl", 32'(io_ctrl), 32'h0);
                sb.delete();
                m_rdata = '0;
            end else begin
                act = 1'b0;
                dn  = 1'b0;
                if (sb.size() > 0) begin
                    t   = sb[0];
                    act = (k >= t.a) && (k < t.done_k);
                    dn  = (k == t.done_k);
                end
                chk("bg", 32'(bg), act ? 32'(t.bg) : 32'h0);
                chk("busy", 32'(cpu_busy), 32'(act));
                chk("io_addr", io_addr, act ? t.addr : 32'h0);
                chk("io_ctrl", 32'(io_ctrl), act ? 32'(t.we) : 32'h0);
                if (act && t.we) chk("io_data", io_data, t.wdata);
                chk("done", 32'(cpu_done), 32'(dn));
                chk("err", 32'(cpu_err), 32'(dn && t.err));
                if (dn) begin
                    if (!t.we) m_rdata = t.rdata;
                    void'(sb.pop_front());
                end
                chk("rdata", cpu_rdata, m_rdata);
            end
        end
    end

    initial begin
        logic        acc;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 32'h0000_0004, 32'h0000_A5A5);
        issue(1'b0, 32'h0000_0000, 32'h0);
        issue(1'b0, 32'h0000_0200, 32'h0);
        issue(1'b0, 32'h0000_0500, 32'h0);
        issue(1'b1, 32'h0000_0500, 32'h1111_2222);
        issue(1'b0, 32'h0000_0104, 32'h0);

        // request held high across several back-to-back loads
        for (int i = 0; i < 12; i++)
            drive(1'b1, 1'b0, 32'h0000_0304, 32'h0, acc);
        drive(1'b0, 1'b0, 32'h0, 32'h0, acc);

        // reset in the middle of a read
        issue(1'b0, 32'h0000_0300, 32'h0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            a       = $urandom;
            a[11:8] = 4'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, acc);
            if ($urandom_range(0, 200) == 0) do_reset();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, acc);

        repeat (10) @(negedge clk);
        chk("drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
